cntr8_os_logic: RTL and testbench
=================================

# cntr8_os_logic

State register and output datapath of the 8-bit up/down counter. Sits directly downstream of the counter's next-state logic: registers the 3-bit next-state code every clock, feeds the registered state back upstream, and maintains the count register that the state sequence commands (clear, load, increment, decrement). Also flags wrap-around and illegal state codes. Instantiated next to the next-state logic inside the counter top level.

## Interface
- WIDTH, 8, count/data width in bits
- clk  input  1  rising-edge clock; sole clock
- reset  input  1  asynchronous, active-high reset
- next_state  input  3  state code from next-state logic
- d_in  input  WIDTH  parallel load value
- state  output  3  registered state, fed back to next-state logic
- d_out  output  WIDTH  registered count
- ovf  output  1  one-cycle pulse: increment wrapped max -> 0
- unf  output  1  one-cycle pulse: decrement wrapped 0 -> max
- err  output  1  one-cycle pulse: illegal next_state code sampled
- One clock; reset is asynchronous and active-high.

## Operation
- State codes: IDLE 000, LOAD 001, INC 010, INC2 011, DEC 100, DEC2 101; 110/111 illegal.
- Each rising edge: state <= next_state (legal code); illegal code -> state <= IDLE, err <= 1.
- Count update uses the code being registered (next_state), same edge:
  - IDLE: d_out <= 0.
  - LOAD: d_out <= d_in (sampled at that edge).
  - INC, INC2: d_out <= d_out + 1, modulo 2^WIDTH.
  - DEC, DEC2: d_out <= d_out - 1, modulo 2^WIDTH.
  - illegal: d_out holds.
- ovf <= 1 iff INC/INC2 and d_out == 2^WIDTH-1 before the edge; else 0.
- unf <= 1 iff DEC/DEC2 and d_out == 0 before the edge; else 0.
- err <= 1 iff next_state is 110 or 111; else 0.
- ovf, unf, err never assert together; all are registered, no combinational path from inputs.
- Arithmetic strictly WIDTH bits; carry/borrow appear only via ovf/unf.

## Timing
- Reset (asynchronous, takes effect immediately, independent of clk): state = IDLE, d_out = 0, ovf = unf = err = 0.
- Reset deassertion: first rising edge after deassertion performs a normal update.
- Reset mid-operation: count and flags cleared at once; pending next_state ignored until reset drops.
- Latency: next_state/d_in sampled at edge k -> state, d_out, flags valid after edge k, held one full cycle.
- Loop: next-state logic is combinational on state; loop closes through this block's register only.
- Pulses last exactly one cycle unless the condition recurs the next edge (e.g. repeated illegal code -> err held high).
- LOAD with d_in = max followed by INC: d_out = 0 and ovf = 1 after the INC edge.

## Structure
- Shared package cntr8_pkg: state code constants (IDLE..DEC2), 3-bit state type, WIDTH default; next-state logic and this block both use it.
- Sub-module cntr8_state_reg: 3-bit async-reset state flip-flops with illegal-code fold to IDLE and err generation. Count datapath and ovf/unf live in cntr8_os_logic.

## Test plan
- Reset asserted mid-count (d_out = 0x5A, state INC) between edges -> d_out = 0x00, state = 000, flags 0 immediately, before next edge.
- next_state LOAD, d_in = 0x3C, then INC, INC2, INC -> d_out 0x3C, 0x3D, 0x3E, 0x3F; state tracks 001, 010, 011, 010.
- LOAD 0xFF then INC -> d_out = 0x00, ovf = 1 for one cycle; following INC2 -> 0x01, ovf = 0.
- LOAD 0x00 then DEC, DEC2 -> d_out 0xFF (unf = 1), 0xFE (unf = 0).
- next_state = 110 with d_out = 0x12 -> state = 000, d_out = 0x12 holds, err = 1 one cycle; next edge IDLE -> d_out = 0x00, err = 0.
- Closed loop with next-state logic: load = 0, inc = 1 for 4 cycles after LOAD 0x10 -> d_out 0x14, state alternates INC/INC2.

Source files
------------

// File: rtl/cntr8_pkg.sv
// Shared definitions for the 8-bit up/down counter: state codes, state type
// and the default datapath width, used by next-state logic and cntr8_os_logic.
package cntr8_pkg;

  localparam int unsigned CNTR8_WIDTH = 8;

  typedef logic [2:0] state_code_t;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LOAD = 3'b001,
    INC  = 3'b010,
    INC2 = 3'b011,
    DEC  = 3'b100,
    DEC2 = 3'b101
  } state_e;

  // Codes 110 and 111 have no meaning and are folded to IDLE by the state register.
  function automatic logic code_is_legal(input state_code_t code);
    return code <= 3'b101;
  endfunction

  function automatic logic code_is_inc(input state_code_t code);
    return (code == INC) || (code == INC2);
  endfunction

  function automatic logic code_is_dec(input state_code_t code);
    return (code == DEC) || (code == DEC2);
  endfunction

endpackage

// File: rtl/cntr8_os_logic_if.sv
// Bus between the counter next-state logic (master) and the state register /
// output datapath (slave).
interface cntr8_os_logic_if
  import cntr8_pkg::*;
#(
  parameter int unsigned WIDTH = CNTR8_WIDTH
);

  state_code_t      next_state;
  logic [WIDTH-1:0] d_in;
  state_code_t      state;
  logic [WIDTH-1:0] d_out;
  logic             ovf;
  logic             unf;
  logic             err;

  modport master (
    output next_state,
    output d_in,
    input  state,
    input  d_out,
    input  ovf,
    input  unf,
    input  err
  );

  modport slave (
    input  next_state,
    input  d_in,
    output state,
    output d_out,
    output ovf,
    output unf,
    output err
  );

endinterface

// File: rtl/cntr8_state_reg.sv
// 3-bit counter state register with asynchronous reset; illegal codes are
// registered as IDLE and raise a one-cycle err pulse.
module cntr8_state_reg
  import cntr8_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  state_code_t next_state,
  output state_code_t state,
  output logic        err
);

  state_e state_d, state_q;
  logic   err_d, err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    err_d   = 1'b0;
    if (code_is_legal(next_state)) begin
      state_d = state_e'(next_state);
    end else begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    state = state_q;
    err   = err_q;
  end

endmodule

// File: rtl/cntr8_os_logic.sv
// Counter state register and output datapath: registers next_state, updates the
// count as commanded by the code being registered, and flags wraps.
module cntr8_os_logic
  import cntr8_pkg::*;
#(
  parameter int unsigned WIDTH = CNTR8_WIDTH
)(
  input logic              clk,
  input logic              reset,
  cntr8_os_logic_if.slave  bus
);

  logic [WIDTH-1:0] d_out_d, d_out_q;
  logic             ovf_d, ovf_q;
  logic             unf_d, unf_q;

  cntr8_state_reg u_state_reg (
    .clk        (clk),
    .reset      (reset),
    .next_state (bus.next_state),
    .state      (bus.state),
    .err        (bus.err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      d_out_q <= d_out_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // The count follows the incoming code on the same edge, not the registered state.
  always_comb begin
    d_out_d = d_out_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    case (bus.next_state)
      IDLE:    d_out_d = '0;
      LOAD:    d_out_d = bus.d_in;
      INC,
      INC2:    d_out_d = d_out_q + WIDTH'(1);
      DEC,
      DEC2:    d_out_d = d_out_q - WIDTH'(1);
      default: d_out_d = d_out_q;
    endcase
    if (code_is_inc(bus.next_state) && (d_out_q == '1)) begin
      ovf_d = 1'b1;
    end
    if (code_is_dec(bus.next_state) && (d_out_q == '0)) begin
      unf_d = 1'b1;
    end
  end

  always_comb begin
    bus.d_out = d_out_q;
    bus.ovf   = ovf_q;
    bus.unf   = unf_q;
  end

endmodule

// File: tb/tb_cntr8_os_logic.sv
// Directed-vector bench for cntr8_os_logic, including a closed loop through a
// small next-state model.
module tb_cntr8_os_logic;
  import cntr8_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        loop_en;
  logic [2:0]  ns_manual;
  logic        m_load, m_inc, m_dec;
  int unsigned nvec = 0;
  int unsigned nerr = 0;

  cntr8_os_logic_if #(.WIDTH(8)) bus ();

  cntr8_os_logic #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ns_model(input logic [2:0] st, input logic ld,
                                          input logic in, input logic de);
    if (ld)      return LOAD;
    else if (in) return (st == INC) ? INC2 : INC;
    else if (de) return (st == DEC) ? DEC2 : DEC;
    else         return IDLE;
  endfunction

  assign bus.next_state = loop_en ? ns_model(bus.state, m_load, m_inc, m_dec) : ns_manual;

  task automatic apply(input logic [2:0] ns, input logic [7:0] din);
    @(negedge clk);
    ns_manual = ns;
    bus.d_in  = din;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; loop_en = 1'b0; ns_manual = IDLE; bus.d_in = 8'h00;
    m_load = 1'b0; m_inc = 1'b0; m_dec = 1'b0;
    #1;
    nvec++;
    if ({bus.state, bus.d_out, bus.ovf, bus.unf, bus.err} !== {3'b000, 8'h00, 3'b000}) begin
      nerr++;
      $display("FAIL reset_init: state=%b d_out=%h flags=%b%b%b want 000/00/000",
               bus.state, bus.d_out, bus.ovf, bus.unf, bus.err);
    end
    @(negedge clk); reset = 1'b0;
    apply(LOAD, 8'h59);
    apply(INC, 8'h00);
    nvec++;
    if ({bus.state, bus.d_out} !== {3'b010, 8'h5A}) begin
      nerr++;
      $display("FAIL reset_precount: state=%b d_out=%h want 010/5a", bus.state, bus.d_out);
    end
    // asynchronous assertion between edges
    #2 reset = 1'b1;
    #1;
    nvec++;
    if ({bus.state, bus.d_out, bus.ovf, bus.unf, bus.err} !== {3'b000, 8'h00, 3'b000}) begin
      nerr++;
      $display("FAIL reset_async: state=%b d_out=%h flags=%b%b%b want 000/00/000",
               bus.state, bus.d_out, bus.ovf, bus.unf, bus.err);
    end
    apply(INC, 8'h00);
    nvec++;
    if ({bus.state, bus.d_out} !== {3'b000, 8'h00}) begin
      nerr++;
      $display("FAIL reset_held: state=%b d_out=%h want 000/00", bus.state, bus.d_out);
    end
    @(negedge clk); reset = 1'b0; ns_manual = INC;
    @(posedge clk); #1;
    nvec++;
    if ({bus.state, bus.d_out, bus.ovf, bus.unf, bus.err} !== {3'b010, 8'h01, 3'b000}) begin
      nerr++;
      $display("FAIL reset_release: state=%b d_out=%h flags=%b%b%b want 010/01/000",
               bus.state, bus.d_out, bus.ovf, bus.unf, bus.err);
    end
  endtask

  task automatic test_inc_seq();
    logic [2:0] ns [4] = '{LOAD, INC, INC2, INC};
    logic [7:0] ed [4] = '{8'h3C, 8'h3D, 8'h3E, 8'h3F};
    logic [2:0] es [4] = '{3'b001, 3'b010, 3'b011, 3'b010};
    for (int i = 0; i < 4; i++) begin
      apply(ns[i], 8'h3C);
      nvec++;
      if ({bus.state, bus.d_out, bus.ovf, bus.unf, bus.err} !== {es[i], ed[i], 3'b000}) begin
        nerr++;
        $display("FAIL inc_seq[%0d]: state=%b d_out=%h flags=%b%b%b want %b/%h/000", i,
                 bus.state, bus.d_out, bus.ovf, bus.unf, bus.err, es[i], ed[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [2:0] ns [3] = '{LOAD, INC, INC2};
    logic [7:0] ed [3] = '{8'hFF, 8'h00, 8'h01};
    logic [2:0] ef [3] = '{3'b000, 3'b100, 3'b000};
    for (int i = 0; i < 3; i++) begin
      apply(ns[i], 8'hFF);
      nvec++;
      if ({bus.d_out, bus.ovf, bus.unf, bus.err} !== {ed[i], ef[i]}) begin
        nerr++;
        $display("FAIL overflow[%0d]: d_out=%h flags=%b%b%b want %h/%b", i,
                 bus.d_out, bus.ovf, bus.unf, bus.err, ed[i], ef[i]);
      end
    end
  endtask

  task automatic test_underflow();
    logic [2:0] ns [3] = '{LOAD, DEC, DEC2};
    logic [7:0] ed [3] = '{8'h00, 8'hFF, 8'hFE};
    logic [2:0] ef [3] = '{3'b000, 3'b010, 3'b000};
    logic [2:0] es [3] = '{3'b001, 3'b100, 3'b101};
    for (int i = 0; i < 3; i++) begin
      apply(ns[i], 8'h00);
      nvec++;
      if ({bus.state, bus.d_out, bus.ovf, bus.unf, bus.err} !== {es[i], ed[i], ef[i]}) begin
        nerr++;
        $display("FAIL underflow[%0d]: state=%b d_out=%h flags=%b%b%b want %b/%h/%b", i,
                 bus.state, bus.d_out, bus.ovf, bus.unf, bus.err, es[i], ed[i], ef[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] ns [4] = '{LOAD, 3'b110, 3'b111, IDLE};
    logic [7:0] di [4] = '{8'h12, 8'hAA, 8'h55, 8'h77};
    logic [7:0] ed [4] = '{8'h12, 8'h12, 8'h12, 8'h00};
    logic [2:0] ef [4] = '{3'b000, 3'b001, 3'b001, 3'b000};
    logic [2:0] es [4] = '{3'b001, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 4; i++) begin
      apply(ns[i], di[i]);
      nvec++;
      if ({bus.state, bus.d_out, bus.ovf, bus.unf, bus.err} !== {es[i], ed[i], ef[i]}) begin
        nerr++;
        $display("FAIL illegal[%0d]: state=%b d_out=%h flags=%b%b%b want %b/%h/%b", i,
                 bus.state, bus.d_out, bus.ovf, bus.unf, bus.err, es[i], ed[i], ef[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] es [4] = '{3'b010, 3'b011, 3'b010, 3'b011};
    logic [7:0] ed [4] = '{8'h11, 8'h12, 8'h13, 8'h14};
    apply(LOAD, 8'h10);
    @(negedge clk);
    m_load = 1'b0; m_inc = 1'b1; m_dec = 1'b0; loop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      nvec++;
      if ({bus.state, bus.d_out, bus.ovf, bus.unf, bus.err} !== {es[i], ed[i], 3'b000}) begin
        nerr++;
        $display("FAIL loop[%0d]: state=%b d_out=%h flags=%b%b%b want %b/%h/000", i,
                 bus.state, bus.d_out, bus.ovf, bus.unf, bus.err, es[i], ed[i]);
      end
    end
    @(negedge clk); loop_en = 1'b0; m_inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_inc_seq();
    test_overflow();
    test_underflow();
    test_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, time limit reached");
    $fatal(1);
  end

endmodule
